// File: rtl/alu_control_pipe.sv
// Registered valid/ready ALU control decoder for the RV32I core (EMPTY/FULL/BUSY stage).
// Define ALU_CTRL_M_EXT_EN to add RV32M decode and the multi-cycle divide/remainder hold.
module alu_control_pipe #(
  parameter int CTRL_W     = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic              op5,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              illegal
);

  if (CTRL_W < 4) begin : g_ctrl_w_chk
    $error("alu_control_pipe: CTRL_W must be at least 4");
  end
  if (DIV_CYCLES < 2) begin : g_div_cycles_chk
    $error("alu_control_pipe: DIV_CYCLES must be at least 2");
  end

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_CTRL_M_EXT_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  localparam int               CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 2);
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
`ifdef ALU_CTRL_M_EXT_EN
    ,
    BUSY  = 2'd2
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       rdy_en;
  logic       accept;
  logic [3:0] dec_code;
  logic       dec_ill;
  logic [3:0] ctrl_p1;
  logic       ill_p1;
`ifdef ALU_CTRL_M_EXT_EN
  logic             dec_div;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Decode (stage p0, combinational on the request fields)
  always_comb begin
    dec_code = OP_ADD;
    dec_ill  = 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
    dec_div  = 1'b0;
`endif
    case (ALUOp)
      2'b00: dec_code = OP_ADD;
      2'b01: dec_code = OP_SUB;
      2'b11: begin
        dec_code = OP_ADD;
        dec_ill  = 1'b1;
      end
      default: begin
        case (funct3)
          3'b000:  dec_code = (op5 && funct7_5) ? OP_SUB : OP_ADD;
          3'b001:  dec_code = OP_SLL;
          3'b010:  dec_code = OP_SLT;
          3'b011:  dec_code = OP_SLTU;
          3'b100:  dec_code = OP_XOR;
          3'b101:  dec_code = funct7_5 ? OP_SRA : OP_SRL;
          3'b110:  dec_code = OP_OR;
          default: dec_code = OP_AND;
        endcase
        if (op5 && funct7_0) begin
`ifdef ALU_CTRL_M_EXT_EN
          case (funct3)
            3'b000:  dec_code = OP_MUL;
            3'b001,
            3'b010,
            3'b011:  dec_code = OP_MULH;
            3'b100:  dec_code = OP_DIV;
            3'b101:  dec_code = OP_DIVU;
            3'b110:  dec_code = OP_REM;
            default: dec_code = OP_REMU;
          endcase
          dec_div = funct3[2];
`else
          dec_ill = 1'b1;
`endif
        end
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  // Handshake FSM; out_valid comes from registered state only
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      EMPTY: begin
        in_ready = rdy_en & ~flush;
        if (accept) begin
          state_d = FULL;
`ifdef ALU_CTRL_M_EXT_EN
          if (dec_div) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
`endif
        end
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~flush;
        if (out_ready) begin
          state_d = accept ? FULL : EMPTY;
`ifdef ALU_CTRL_M_EXT_EN
          if (accept && dec_div) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
`endif
        end
      end
`ifdef ALU_CTRL_M_EXT_EN
      BUSY: begin
        if (cnt_q == '0) state_d = FULL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Stage p1: state and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      rdy_en  <= 1'b0;
      ctrl_p1 <= '0;
      ill_p1  <= 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_en  <= 1'b1;
`ifdef ALU_CTRL_M_EXT_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        ctrl_p1 <= dec_code;
        ill_p1  <= dec_ill;
      end
    end
  end

  assign ALUControl = CTRL_W'(ctrl_p1);
  assign illegal    = ill_p1;

endmodule

// File: doc/alu_control_pipe.md
# alu_control_pipe

Registered, handshaked ALU control decoder for the RV32I core; successor to the single-cycle combinational ALU decoder. It decodes ALUOp/funct3/funct7 into a widened ALUControl code covering the full RV32I ALU op set and, optionally, RV32M. Sits between the main decoder and the execute stage, with a valid/ready interface on both sides. When M is compiled in, it holds divide/remainder ops for a programmable occupancy latency.

## Interface
- CTRL_W, 4: ALUControl width, minimum 4; bits above [3] are driven 0.
- DIV_CYCLES, 32: cycles from DIV/REM accept to out_valid, minimum 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous abort; empties the stage.
- in_valid  input  1  decode request present.
- in_ready  output  1  stage accepts a request this cycle.
- ALUOp  input  2  class from main decoder.
- op5  input  1  opcode bit 5 (1 = R-type).
- funct3  input  3  instruction bits [14:12].
- funct7_5  input  1  instruction bit 30.
- funct7_0  input  1  instruction bit 25 (M select).
- out_valid  output  1  ALUControl/illegal valid.
- out_ready  input  1  execute stage consumes the output.
- ALUControl  output  CTRL_W  registered ALU op code.
- illegal  output  1  registered illegal-encoding flag.

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, MUL 1010, MULH 1011, DIV 1100, DIVU 1101, REM 1110, REMU 1111.
- ALUOp 00 -> ADD. ALUOp 01 -> SUB.
- ALUOp 11 -> ADD with illegal=1.
- ALUOp 10, funct3 decode:
  - 000 -> SUB if {op5,funct7_5}==11, else ADD.
  - 001 -> SLL. 010 -> SLT. 011 -> SLTU. 100 -> XOR.
  - 101 -> SRA if funct7_5, else SRL.
  - 110 -> OR. 111 -> AND.
- M decode (macro on) applies when ALUOp 10, op5=1, funct7_0=1:
  - 000 -> MUL. 001/010/011 -> MULH.
  - 100 -> DIV. 101 -> DIVU. 110 -> REM. 111 -> REMU.
- Div-class ops are DIV, DIVU, REM and REMU.
- FSM states EMPTY, FULL, BUSY; cnt width $clog2(DIV_CYCLES).
- EMPTY: out_valid=0, in_ready=!flush.
  - Accept non-div -> FULL.
  - Accept div-class -> BUSY, cnt=DIV_CYCLES-2.
- BUSY: out_valid=0, in_ready=0.
  - cnt!=0 -> cnt-1.
  - cnt==0 -> FULL.
- FULL: out_valid=1, in_ready=out_ready&!flush.
  - out_ready&in_valid -> load new op: FULL, or BUSY if div-class.
  - out_ready&!in_valid -> EMPTY.
  - !out_ready -> hold; ALUControl and illegal stable.
- Output register loads only on an accepted transfer (in_valid&in_ready).
- flush: next state EMPTY from any state; aborts BUSY. Flush wins over a simultaneous in_valid, because in_ready=0 while flush is high.
- Reset (rst low, any time including mid-BUSY): state EMPTY, cnt 0, out_valid 0, ALUControl 0, illegal 0, in_ready 0 while held. in_ready rises the first cycle after release.

## Timing
- Non-div op accepted at edge T: out_valid=1 in cycle T+1 (1-cycle latency).
- Div-class op accepted at edge T: out_valid=1 in cycle T+DIV_CYCLES.
- Back-to-back throughput: 1 op/cycle in FULL with out_ready=1.
- No combinational path from in_valid to out_valid.
- The only combinational path from out_ready is to in_ready.

## Configuration
- ALU_CTRL_M_EXT_EN defined:
  - M decode active; BUSY state and cnt present.
  - R-type with funct7_0=1 decodes per the M table with illegal=0.
- ALU_CTRL_M_EXT_EN undefined:
  - No BUSY or cnt logic.
  - R-type with funct7_0=1 decodes via the base table, illegal=1.
  - All ops have 1-cycle latency.

## Test plan
- Reset/idle: rst=0 mid-stream -> out_valid=0, ALUControl=0000, illegal=0; in_ready=1 in the cycle after release.
- Base decode: ALUOp=10, op5=1, funct7_5=1, funct3=000 -> 0001 next cycle; funct3=101, funct7_5=1 -> 1001; ALUOp=11 -> 0000 with illegal=1.
- Backpressure: FULL with AND (0010), out_ready=0 for 5 cycles while in_valid=1 with OR -> ALUControl stays 0010, in_ready=0. out_ready=1 -> OR (0011) valid the next cycle.
- Divide latency (M on, DIV_CYCLES=4): DIV accepted at cycle 10 -> out_valid low through cycle 13, 1100 valid at cycle 14; in_ready=0 during cycles 11-13.
- Flush: flush=1 during BUSY cycle 2 with in_valid=1 -> EMPTY next cycle, out_valid never asserts, the input is not accepted.
- M off: funct7_0=1, funct3=100 -> XOR (0100) with illegal=1, 1-cycle latency.
